div_unit: RTL

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. Sits in the execute stage alongside the ALU. Its registered `result` drives one data input of the 5-way writeback/forwarding result mux, and its `busy` output stalls the pipeline while an operation is in flight. One quotient bit is produced per cycle.

---
 rtl/div_unit.sv | 90 +++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; optional DIV_EARLY_OUT_EN finishes b==0 and signed overflow in one cycle
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem, rem_n;
  logic [WIDTH+1:0] rem_sh, diff;
  logic [WIDTH-1:0] quo, quo_n, dvs, a_abs, b_abs, q_fix, r_fix;
  logic             rem_op, neg_a, neg_b, dz, sa, sb, ge, last, accept, early;
`ifdef DIV_EARLY_OUT_EN
  logic             ov;
  logic [WIDTH-1:0] early_res;
  assign ov        = sa && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1;
  assign early     = b == '0 || ov;
  assign early_res = b == '0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);
`else
  assign early = 1'b0;
`endif
  assign sa     = ~op[0] & a[WIDTH-1];
  assign sb     = ~op[0] & b[WIDTH-1];
  assign a_abs  = sa ? -a : a;
  assign b_abs  = sb ? -b : b;
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {2'b0, dvs};
  assign ge     = ~diff[WIDTH+1];
  assign rem_n  = ge ? diff[WIDTH:0] : rem_sh[WIDTH:0];
  assign quo_n  = {quo[WIDTH-2:0], ge};
  assign q_fix  = dz ? '1 : (neg_a ^ neg_b) ? -quo_n : quo_n;
  assign r_fix  = neg_a ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];
  assign last   = cnt == CW'(WIDTH - 1);
  assign accept = start && !flush && state != RUN;
  assign busy   = state == RUN;
  assign done   = state == DONE;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: flush wins over everything, start is only honoured outside RUN
  always_comb begin
    state_n = IDLE;
    if (flush) state_n = IDLE;
    else if (state == RUN) state_n = last ? DONE : RUN;
    else if (start) state_n = early ? DONE : RUN;
  end
  // operand capture, one shift-subtract step per RUN cycle, result load with sign fixup
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_op <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      dz     <= 1'b0;
      quo    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      rem_op <= op[1];
      neg_a  <= sa;
      neg_b  <= sb;
      dz     <= b == '0;
      quo    <= a_abs;
      dvs    <= b_abs;
      rem    <= '0;
      cnt    <= '0;
`ifdef DIV_EARLY_OUT_EN
      if (early) result <= early_res;
`endif
    end else if (state == RUN && !flush) begin
      quo <= quo_n;
      rem <= rem_n;
      cnt <= cnt + 1'b1;
      if (last) result <= rem_op ? r_fix : q_fix;
    end
  end
endmodule
